// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller driving one full_adder cell over WIDTH cycles
// Optional subtract mode (sub port) is compiled in with SERIAL_ADD_SUB_EN.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             fa_b;
   logic             fa_s;
   logic             fa_co;
   logic             load_carry;

`ifdef SERIAL_ADD_SUB_EN
   logic sub_r;
   // Subtract as a + ~b + 1: invert B bits and seed the carry with 1.
   assign fa_b       = sh_b[0] ^ sub_r;
   assign load_carry = sub ? 1'b1 : cin;
`else
   assign fa_b       = sh_b[0];
   assign load_carry = cin;
`endif

   full_adder u_fa (
      .a  (sh_a[0]),
      .b  (fa_b),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // Written this way so the MSB insert also works for WIDTH == 1.
   always_comb begin
      res_next            = res >> 1;
      res_next[WIDTH-1]   = fa_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sh_a  <= '0;
         sh_b  <= '0;
         res   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         sub_r <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sh_a  <= a;
                  sh_b  <= b;
                  carry <= load_carry;
                  cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                  sub_r <= sub;
`endif
                  state <= RUN;
               end
            end
            RUN: begin
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               res   <= res_next;
               carry <= fa_co;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST_BIT) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = res;
   // After the last bit the carry flop holds the true carry out of bit WIDTH-1.
   assign cout      = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed-vector bench for serial_add_ctrl (WIDTH=8)
// Subtract vectors run only when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       sub;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;

   int n_vec = 0;
   int n_err = 0;
   int cyc_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out_valid(output int cycles);
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 50) begin
         tick();
         cycles++;
      end
      check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic wait_in_ready;
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vcin, input logic vsub,
                          input logic [7:0] exp_sum, input logic exp_cout);
      int lat;
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 8'hC3; b = 8'h3C; cin = ~vcin;
      wait_out_valid(lat);
      check({tag, "_latency"}, lat, 32'd8);
      check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
   endtask

   logic [7:0] bb_a [3] = '{8'h01, 8'h80, 8'h7F};
   logic [7:0] bb_b [3] = '{8'h01, 8'h80, 8'h01};
   logic [8:0] bb_r [3] = '{9'h002, 9'h100, 9'h080};
   int acc_cyc [3];

   initial begin
      int lat;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum_cout", {23'd0, cout, sum}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      run_add("basic", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
      run_add("ff_p_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
      run_add("ff_p_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
      run_add("zero_c", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);

      // Backpressure with a competing operand request held in DONE
      a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out_valid(lat);
      a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold", {22'd0, out_valid, in_ready, cout, sum}, {22'd0, 1'b1, 1'b0, 1'b0, 8'h46});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);

      // Reset while bit 3 is being processed
      a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check("midrun_rst", {21'd0, in_ready, out_valid, cout, sum}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
      tick();
      rst_n = 1'b1;
      tick();
      run_add("after_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);

      // Back-to-back with in_valid and out_ready held high
      in_valid = 1'b1; out_ready = 1'b1; cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = bb_a[i]; b = bb_b[i];
         wait_in_ready();
         @(posedge clk);
         acc_cyc[i] = cyc_cnt;
         #1;
         wait_out_valid(lat);
         check("b2b_result", {23'd0, cout, sum}, {23'd0, bb_r[i]});
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 32'd10);
      check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 32'd10);

`ifdef SERIAL_ADD_SUB_EN
      run_add("sub_pos", 8'h10, 8'h03, 1'b0, 1'b1, 8'h0D, 1'b1);
      run_add("sub_neg", 8'h03, 8'h10, 1'b1, 1'b1, 8'hF3, 1'b0);
      run_add("sub0_add", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
